fetch_unit: RTL and testbench

Instruction fetch and decode stage sitting directly upstream of the 16-bit ALU. Owns the program counter, fetches 16-bit instruction words from instruction memory over a request/acknowledge interface, and splits each word into the ALU control fields (op, eq, ltgt) and operand selectors. Branches are not speculated: after issuing a branch the unit waits for the ALU's compare result (`compres`) and then redirects the PC.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/instr_decode.sv | 22 ++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions and the fetch FSM state type.
// Imported by the fetch stage, the instruction splitter and later pipeline stages.
package cpu_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_BRANCH = 4'b0100;
  localparam logic [3:0] OP_EPAR   = 4'b0101;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int EQ_BIT   = 11;
  localparam int LTGT_MSB = 10;
  localparam int LTGT_LSB = 8;
  localparam int RS_MSB   = 7;
  localparam int RS_LSB   = 4;
  localparam int RD_MSB   = 3;
  localparam int RD_LSB   = 0;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_BR,
    ST_HALT
  } fetch_state_e;

  // Branch offsets are signed 8-bit word displacements.
  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Purely combinational split of a 16-bit instruction word into its control
// fields and operand selectors.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [15:0] instr,
  output logic [3:0]  op,
  output logic        eq,
  output logic [2:0]  ltgt,
  output logic [3:0]  rs,
  output logic [3:0]  rd,
  output logic [7:0]  imm
);

  assign op   = instr[OP_MSB:OP_LSB];
  assign eq   = instr[EQ_BIT];
  assign ltgt = instr[LTGT_MSB:LTGT_LSB];
  assign rs   = instr[RS_MSB:RS_LSB];
  assign rd   = instr[RD_MSB:RD_LSB];
  assign imm  = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/decode stage: owns the PC, fetches over req/ack, presents
// decoded fields downstream and stalls on branches until the ALU resolves them.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [3:0]  dec_op,
  output logic        dec_eq,
  output logic [2:0]  dec_ltgt,
  output logic [3:0]  dec_rs,
  output logic [3:0]  dec_rd,
  output logic [7:0]  dec_imm,
  output logic [15:0] dec_pc,
  input  logic        branch_resolve,
  input  logic        compres,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  dec_pc_q, dec_pc_d;
  logic [15:0]  br_target;

  instr_decode u_decode (
    .instr (instr_q),
    .op    (dec_op),
    .eq    (dec_eq),
    .ltgt  (dec_ltgt),
    .rs    (dec_rs),
    .rd    (dec_rd),
    .imm   (dec_imm)
  );

  // Wraps modulo 2^16 by width truncation.
  assign br_target = dec_pc_q + sext8(dec_imm);
  assign imem_addr = pc_q;
  assign dec_pc    = dec_pc_q;
  assign halted    = (state_q == ST_HALT) && !reset;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    dec_pc_d  = dec_pc_q;
    imem_req  = 1'b0;
    dec_valid = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d  = imem_data;
          dec_pc_d = pc_q;
          pc_d     = pc_q + 16'd1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        dec_valid = 1'b1;
        if (dec_ready) begin
          if (dec_op == OP_HALT) begin
            state_d = ST_HALT;
          end else if (dec_op == OP_BRANCH) begin
            if (branch_resolve) begin
              if (compres) pc_d = br_target;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WAIT_BR;
            end
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_WAIT_BR: begin
        // Not-taken needs no update: the PC already points past the branch.
        if (branch_resolve) begin
          if (compres) pc_d = br_target;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
      end
      default: state_d = ST_FETCH;
    endcase

    // Handshake outputs stay quiet while reset is held, whatever the old state.
    if (reset) begin
      imem_req  = 1'b0;
      dec_valid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      dec_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      dec_pc_q <= dec_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scripted instruction memory pushes
// expected decodes into a scoreboard that is popped at each ISSUE.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [3:0]  dec_op;
  logic        dec_eq;
  logic [2:0]  dec_ltgt;
  logic [3:0]  dec_rs;
  logic [3:0]  dec_rd;
  logic [7:0]  dec_imm;
  logic [15:0] dec_pc;
  logic        branch_resolve = 1'b0;
  logic        compres = 1'b0;
  logic        halted;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [23:0] fields;  // {op, eq, ltgt, rs, rd, imm}
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_op         (dec_op),
    .dec_eq         (dec_eq),
    .dec_ltgt       (dec_ltgt),
    .dec_rs         (dec_rs),
    .dec_rd         (dec_rd),
    .dec_imm        (dec_imm),
    .dec_pc         (dec_pc),
    .branch_resolve (branch_resolve),
    .compres        (compres),
    .halted         (halted)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [23:0] dec_now();
    return {dec_op, dec_eq, dec_ltgt, dec_rs, dec_rd, dec_imm};
  endfunction

  // Waits for a request, checks the address, holds it lat cycles, then acks.
  task automatic do_fetch(input logic [15:0] exp_addr, input logic [15:0] word, input int lat);
    int   n;
    exp_t e;
    n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_req_timeout: imem_req=%b required 1", imem_req);
      return;
    end
    checks++;
    if (imem_addr !== exp_addr) begin
      errors++;
      $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, exp_addr);
    end
    for (int i = 0; i < lat; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
        errors++;
        $display("FAIL fetch_addr_stable: req=%b addr=%h required 1 %h", imem_req, imem_addr, exp_addr);
      end
    end
    imem_ack  = 1'b1;
    imem_data = word;
    e.fields  = {word[15:12], word[11], word[10:8], word[7:4], word[3:0], word[7:0]};
    e.pc      = exp_addr;
    sb.push_back(e);
    tick();
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
  endtask

  // Called the cycle after the ack: checks the presented decode, stalls, handshakes.
  task automatic do_issue(input int stall);
    exp_t e;
    checks++;
    if (dec_valid !== 1'b1) begin
      errors++;
      $display("FAIL issue_valid: dec_valid=%b required 1", dec_valid);
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: decode seen with nothing expected");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (dec_now() !== e.fields || dec_pc !== e.pc) begin
      errors++;
      $display("FAIL issue_fields: fields=%h pc=%h required %h %h", dec_now(), dec_pc, e.fields, e.pc);
    end
    for (int i = 0; i < stall; i++) begin
      dec_ready = 1'b0;
      tick();
      checks++;
      if (dec_valid !== 1'b1 || imem_req !== 1'b0 || dec_now() !== e.fields ||
          dec_pc !== e.pc || imem_addr !== e.pc + 16'd1) begin
        errors++;
        $display("FAIL issue_stall: valid=%b req=%b fields=%h pc=%h addr=%h required 1 0 %h %h %h",
                 dec_valid, imem_req, dec_now(), dec_pc, imem_addr, e.fields, e.pc, e.pc + 16'd1);
      end
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || dec_valid !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b addr=%h valid=%b halted=%b required 0 0000 0 0",
               imem_req, imem_addr, dec_valid, halted);
    end
    checks++;
    if (dec_now() !== 24'h0 || dec_pc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_fields: fields=%h pc=%h required 0 0", dec_now(), dec_pc);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_first_fetch: req=%b addr=%h required 1 0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    do_fetch(16'h0000, 16'h0012, 0);
    do_issue(0);
    do_fetch(16'h0001, 16'h1034, 0);
    do_issue(0);
  endtask

  // Stray branch_resolve on a non-branch must not move the PC.
  task automatic test_stall();
    do_fetch(16'h0002, 16'h0156, 2);
    branch_resolve = 1'b1;
    compres        = 1'b1;
    do_issue(5);
    branch_resolve = 1'b0;
    compres        = 1'b0;
  endtask

  task automatic wait_resolve(input logic taken);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (dec_valid !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL wait_br_idle: valid=%b req=%b required 0 0", dec_valid, imem_req);
      end
    end
    branch_resolve = 1'b1;
    compres        = taken;
    tick();
    branch_resolve = 1'b0;
    compres        = 1'b0;
  endtask

  task automatic test_branch_wait();
    // Taken-at-handshake branch from 0x0003 by +12 lands on 0x000F.
    do_fetch(16'h0003, 16'h400C, 0);
    branch_resolve = 1'b1;
    compres        = 1'b1;
    do_issue(0);
    branch_resolve = 1'b0;
    compres        = 1'b0;
    do_fetch(16'h000F, 16'h0000, 0);
    do_issue(0);
    do_fetch(16'h0010, 16'h4305, 0);
    do_issue(0);
    wait_resolve(1'b1);
    // 0x0015 - 5 returns to 0x0010 for the not-taken run.
    do_fetch(16'h0015, 16'h40FB, 1);
    branch_resolve = 1'b1;
    compres        = 1'b1;
    do_issue(0);
    branch_resolve = 1'b0;
    compres        = 1'b0;
    do_fetch(16'h0010, 16'h4305, 0);
    do_issue(0);
    wait_resolve(1'b0);
    do_fetch(16'h0011, 16'h1034, 0);
    do_issue(0);
  endtask

  task automatic test_branch_wrap();
    apply_reset(1);
    do_fetch(16'h0000, 16'h4080, 0);
    branch_resolve = 1'b1;
    compres        = 1'b1;
    do_issue(0);
    branch_resolve = 1'b0;
    compres        = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'hFF80) begin
      errors++;
      $display("FAIL branch_wrap: req=%b addr=%h required 1 ff80", imem_req, imem_addr);
    end
  endtask

  task automatic test_halt();
    do_fetch(16'hFF80, 16'hF000, 0);
    do_issue(0);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_flag: halted=%b required 1", halted);
    end
    for (int i = 0; i < 20; i++) begin
      imem_ack  = i[0];
      imem_data = 16'h0012;
      dec_ready = 1'b1;
      tick();
      checks++;
      if (imem_req !== 1'b0 || dec_valid !== 1'b0 || halted !== 1'b1) begin
        errors++;
        $display("FAIL halt_idle: req=%b valid=%b halted=%b required 0 0 1", imem_req, dec_valid, halted);
      end
    end
    imem_ack  = 1'b0;
    dec_ready = 1'b0;
    apply_reset(1);
    checks++;
    if (imem_addr !== 16'h0000 || halted !== 1'b0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL halt_reset: addr=%h halted=%b req=%b required 0000 0 1", imem_addr, halted, imem_req);
    end
  endtask

  // Ack for an abandoned fetch lands while reset is still held.
  task automatic test_reset_midfetch();
    do_fetch(16'h0000, 16'h0012, 0);
    do_issue(0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    imem_ack  = 1'b1;
    imem_data = 16'h1234;
    tick();
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
    reset     = 1'b0;
    #1;
    checks++;
    if (dec_valid !== 1'b0 || imem_addr !== 16'h0000 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL midfetch_reset: valid=%b addr=%h req=%b required 0 0000 1", dec_valid, imem_addr, imem_req);
    end
    tick();
    checks++;
    if (dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL midfetch_ack_dropped: dec_valid=%b required 0", dec_valid);
    end
    do_fetch(16'h0000, 16'h1034, 0);
    do_issue(0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_branch_wrap();
    test_halt();
    test_reset_midfetch();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
